// File: rtl/wb_stage_regfile_if.sv
// MEM/WB write-back bundle: pipeline inputs, decode read ports and retire status.
interface wb_stage_regfile_if #(
    parameter int data_bits = 32
);
    logic                 wb_valid;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic [2:0]           load_funct3;
    logic [1:0]           addr_low;
    logic [data_bits-1:0] alu_result_in;
    logic [data_bits-1:0] data_memory_out_in;
    logic [4:0]           instruction_11_7_in;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [data_bits-1:0] rs1_data;
    logic [data_bits-1:0] rs2_data;
    logic [data_bits-1:0] wb_data;
    logic                 wb_write_en;
    logic [31:0]          retired_count;

    modport master (
        output wb_valid, reg_write, mem_to_reg, load_funct3, addr_low,
               alu_result_in, data_memory_out_in, instruction_11_7_in,
               rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_write_en, retired_count
    );

    modport slave (
        input  wb_valid, reg_write, mem_to_reg, load_funct3, addr_low,
               alu_result_in, data_memory_out_in, instruction_11_7_in,
               rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_write_en, retired_count
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// Write-back stage: load formatting, 32x32 register file with write-through read bypass, retire counter.
// Latency: wb_data/read ports combinational, storage updated at the rising edge. No backpressure.
module wb_stage_regfile #(
    parameter int data_bits = 32,
    parameter int reg_count = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    wb_stage_regfile_if.slave bus
);
    logic [data_bits-1:0] r_regs [reg_count];
    logic [31:0]          r_retired_count;

    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [data_bits-1:0] w_load;
    logic [data_bits-1:0] w_wb_data;
    logic                 w_write_en;
    logic [data_bits-1:0] w_rs1_data;
    logic [data_bits-1:0] w_rs2_data;

    // Halves ignore addr_low[0]: a misaligned LH/LHU silently reads the containing half.
    always_comb begin
        w_byte = bus.data_memory_out_in[{bus.addr_low, 3'b000} +: 8];
        w_half = bus.addr_low[1] ? bus.data_memory_out_in[31:16]
                                 : bus.data_memory_out_in[15:0];
        case (bus.load_funct3)
            3'b000:  w_load = {{(data_bits-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(data_bits-16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(data_bits-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(data_bits-16){1'b0}}, w_half};
            default: w_load = bus.data_memory_out_in;
        endcase
    end

    assign w_wb_data  = bus.mem_to_reg ? w_load : bus.alu_result_in;
    assign w_write_en = bus.wb_valid & bus.reg_write & (bus.instruction_11_7_in != 5'd0);

    // Bypass only on a committing write; x0 is hard-wired regardless of rd.
    always_comb begin
        if (bus.rs1_addr == 5'd0)
            w_rs1_data = '0;
        else if (w_write_en && (bus.rs1_addr == bus.instruction_11_7_in))
            w_rs1_data = w_wb_data;
        else
            w_rs1_data = r_regs[bus.rs1_addr];

        if (bus.rs2_addr == 5'd0)
            w_rs2_data = '0;
        else if (w_write_en && (bus.rs2_addr == bus.instruction_11_7_in))
            w_rs2_data = w_wb_data;
        else
            w_rs2_data = r_regs[bus.rs2_addr];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < reg_count; i++)
                r_regs[i] <= '0;
        end else if (w_write_en) begin
            r_regs[bus.instruction_11_7_in] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_retired_count <= '0;
        else if (bus.wb_valid)
            r_retired_count <= r_retired_count + 32'd1;
    end

    assign bus.rs1_data      = w_rs1_data;
    assign bus.rs2_data      = w_rs2_data;
    assign bus.wb_data       = w_wb_data;
    assign bus.wb_write_en   = w_write_en;
    assign bus.retired_count = r_retired_count;
endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboard bench for wb_stage_regfile: expectations queued at drive time, popped at compare.
module tb_wb_stage_regfile;
    logic clk;
    logic n_rst;

    wb_stage_regfile_if #(.data_bits(32)) bus ();

    wb_stage_regfile #(.data_bits(32), .reg_count(32)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    logic [31:0] model_rf [32];
    logic [31:0] model_cnt;

    task automatic drive(input logic v, input logic rw, input logic mtr,
                         input logic [2:0] f3, input logic [1:0] al,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        bus.wb_valid            = v;
        bus.reg_write           = rw;
        bus.mem_to_reg          = mtr;
        bus.load_funct3         = f3;
        bus.addr_low            = al;
        bus.alu_result_in       = alu;
        bus.data_memory_out_in  = mem;
        bus.instruction_11_7_in = rd;
        bus.rs1_addr            = r1;
        bus.rs2_addr            = r2;
    endtask

    // Advance through one rising edge and update the reference state from the presented slot.
    task automatic commit(input logic [31:0] wval);
        @(posedge clk);
        if (n_rst && bus.wb_valid) begin
            model_cnt = model_cnt + 32'd1;
            if (bus.reg_write && bus.instruction_11_7_in != 5'd0)
                model_rf[bus.instruction_11_7_in] = wval;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        model_cnt = 32'd0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(31 - i);
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            #1;
            exp = exp_q.pop_front(); vectors++;
            if (bus.rs1_data !== exp) begin
                miscompares++;
                $display("FAIL reset_rs1[%0d]: got %h want %h", i, bus.rs1_data, exp);
            end
            exp = exp_q.pop_front(); vectors++;
            if (bus.rs2_data !== exp) begin
                miscompares++;
                $display("FAIL reset_rs2[%0d]: got %h want %h", 31 - i, bus.rs2_data, exp);
            end
        end
        exp_q.push_back(32'd0);
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++;
            $display("FAIL reset_count: got %h want %h", bus.retired_count, exp);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd3, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd5);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL bypass_rs1: got %h want %h", bus.rs1_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs2_data !== exp) begin
            miscompares++; $display("FAIL bypass_rs2: got %h want %h", bus.rs2_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if ({31'd0, bus.wb_write_en} !== exp) begin
            miscompares++; $display("FAIL bypass_wen: got %b want %h", bus.wb_write_en, exp);
        end
        commit(32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL stored_rs1: got %h want %h", bus.rs1_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL count_after_write: got %h want %h", bus.retired_count, exp);
        end
        // Bubble must not write even with reg_write set, and must not bypass.
        bus.alu_result_in = 32'h0BAD0BAD;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if ({31'd0, bus.wb_write_en} !== exp) begin
            miscompares++; $display("FAIL bubble_wen: got %b want %h", bus.wb_write_en, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL bubble_nobypass: got %h want %h", bus.rs1_data, exp);
        end
        commit(32'h0BAD0BAD);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL bubble_nowrite: got %h want %h", bus.rs1_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL bubble_nocount: got %h want %h", bus.retired_count, exp);
        end
    endtask

    task automatic test_x0_write();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h12345678, 32'h0, 5'd0, 5'd0, 5'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if ({31'd0, bus.wb_write_en} !== exp) begin
            miscompares++; $display("FAIL x0_wen: got %b want %h", bus.wb_write_en, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.wb_data !== exp) begin
            miscompares++; $display("FAIL x0_wbdata: got %h want %h", bus.wb_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL x0_bypass: got %h want %h", bus.rs1_data, exp);
        end
        commit(32'h12345678);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd2);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs2_data !== exp) begin
            miscompares++; $display("FAIL x0_read: got %h want %h", bus.rs2_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL x0_count: got %h want %h", bus.retired_count, exp);
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3_t  [10] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010,
                                    3'b000, 3'b100, 3'b011, 3'b111};
        logic [1:0]  al_t  [10] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2};
        logic [31:0] exp_t [10] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                    32'h00007F01, 32'h80FF7F01, 32'hFFFFFFFF, 32'h0000007F,
                                    32'h80FF7F01, 32'h80FF7F01};
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b1, f3_t[k], al_t[k], 32'h5555AAA0, 32'h80FF7F01,
                  5'd7, 5'd7, 5'd0);
            exp_q.push_back(exp_t[k]);
            exp_q.push_back(exp_t[k]);
            #1;
            exp = exp_q.pop_front(); vectors++;
            if (bus.wb_data !== exp) begin
                miscompares++; $display("FAIL load_wbdata[%0d]: got %h want %h", k, bus.wb_data, exp);
            end
            exp = exp_q.pop_front(); vectors++;
            if (bus.rs1_data !== exp) begin
                miscompares++; $display("FAIL load_bypass[%0d]: got %h want %h", k, bus.rs1_data, exp);
            end
            commit(exp_t[k]);
            drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7);
            exp_q.push_back(model_rf[7]);
            #1;
            exp = exp_q.pop_front(); vectors++;
            if (bus.rs2_data !== exp) begin
                miscompares++; $display("FAIL load_stored[%0d]: got %h want %h", k, bus.rs2_data, exp);
            end
        end
        // mem_to_reg=0 must pick the ALU result even for a load funct3.
        drive(1'b0, 1'b0, 1'b0, 3'b000, 2'd3, 32'h5555AAA0, 32'h80FF7F01, 5'd7, 5'd0, 5'd0);
        exp_q.push_back(32'h5555AAA0);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.wb_data !== exp) begin
            miscompares++; $display("FAIL alu_select: got %h want %h", bus.wb_data, exp);
        end
        commit(32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        for (int k = 1; k <= 6; k++) begin
            val = 32'h01010101 * k + 32'h0000F000;
            drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, val, 32'h0, 5'(k), 5'(k - 1), 5'(k));
            exp_q.push_back(model_rf[k - 1]);
            exp_q.push_back(val);
            #1;
            exp = exp_q.pop_front(); vectors++;
            if (bus.rs1_data !== exp) begin
                miscompares++; $display("FAIL b2b_prev[%0d]: got %h want %h", k, bus.rs1_data, exp);
            end
            exp = exp_q.pop_front(); vectors++;
            if (bus.rs2_data !== exp) begin
                miscompares++; $display("FAIL b2b_bypass[%0d]: got %h want %h", k, bus.rs2_data, exp);
            end
            commit(val);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        exp_q.push_back(model_rf[5]);
        exp_q.push_back(model_rf[7]);
        exp_q.push_back(model_cnt);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL b2b_x5: got %h want %h", bus.rs1_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs2_data !== exp) begin
            miscompares++; $display("FAIL b2b_x7: got %h want %h", bus.rs2_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL b2b_count: got %h want %h", bus.retired_count, exp);
        end
    endtask

    task automatic test_count_wrap();
        logic [31:0] want_t [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00000001};
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        force dut.r_retired_count = 32'hFFFFFFFE;
        #1;
        release dut.r_retired_count;
        model_cnt = 32'hFFFFFFFE;
        exp_q.push_back(32'hFFFFFFFE);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL wrap_preload: got %h want %h", bus.retired_count, exp);
        end
        for (int k = 0; k < 4; k++) begin
            // Three store-like valid slots (no reg write) then one bubble.
            drive(k < 3, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0);
            exp_q.push_back(want_t[k]);
            commit(32'h0);
            exp = exp_q.pop_front(); vectors++;
            if (bus.retired_count !== exp) begin
                miscompares++; $display("FAIL wrap_step[%0d]: got %h want %h", k, bus.retired_count, exp);
            end
            vectors++;
            if (bus.retired_count !== model_cnt) begin
                miscompares++; $display("FAIL wrap_model[%0d]: got %h want %h", k, bus.retired_count, model_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hA5A5A5A5, 32'h0, 5'd9, 5'd0, 5'd0);
        commit(32'hA5A5A5A5);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL pre_reset_x9: got %h want %h", bus.rs1_data, exp);
        end
        #1;
        n_rst = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        model_cnt = 32'd0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs2_data !== exp) begin
            miscompares++; $display("FAIL async_reset_x9: got %h want %h", bus.rs2_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL async_reset_count: got %h want %h", bus.retired_count, exp);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h55555555, 32'h0, 5'd9, 5'd0, 5'd0);
        commit(32'h55555555);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL write_in_reset: got %h want %h", bus.rs1_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL count_in_reset: got %h want %h", bus.retired_count, exp);
        end
        @(negedge clk);
        n_rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000C0DE, 32'h0, 5'd9, 5'd0, 5'd0);
        commit(32'h0000C0DE);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        exp_q.push_back(32'h0000C0DE);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (bus.rs1_data !== exp) begin
            miscompares++; $display("FAIL first_write_after_reset: got %h want %h", bus.rs1_data, exp);
        end
        exp = exp_q.pop_front(); vectors++;
        if (bus.retired_count !== exp) begin
            miscompares++; $display("FAIL count_after_reset: got %h want %h", bus.retired_count, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_bypass();
        test_x0_write();
        test_load_format();
        test_back_to_back();
        test_count_wrap();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
Write-back end of the MEM/WB pipeline boundary. Consumes the registered MEM/WB outputs (ALU result, data-memory word, destination index) and selects the write-back value. It formats load data (byte/half, signed/unsigned) and commits the value to the 32x32 integer register file. It also serves the two decode-stage read ports with same-cycle write bypass and keeps a retired-instruction counter.

Parameters:
data_bits, 32, datapath and register width
reg_count, 32, number of architectural registers (index width fixed at 5)

Ports:
clk  input  1  rising-edge clock
n_rst  input  1  asynchronous active-low reset
wb_valid  input  1  MEM/WB slot holds a real instruction (0 = bubble)
reg_write  input  1  instruction writes rd
mem_to_reg  input  1  1 = select formatted memory data, 0 = select ALU result
load_funct3  input  3  RISC-V load funct3 of the instruction in WB
addr_low  input  2  ALU result bits [1:0] (byte offset of load)
alu_result_in  input  data_bits  ALU result from MEM/WB
data_memory_out_in  input  data_bits  raw 32-bit memory word from MEM/WB
instruction_11_7_in  input  5  rd index from MEM/WB
rs1_addr  input  5  decode read port 1 index
rs2_addr  input  5  decode read port 2 index
rs1_data  output  data_bits  read port 1 data (combinational)
rs2_data  output  data_bits  read port 2 data (combinational)
wb_data  output  data_bits  selected write-back value (combinational, for forwarding)
wb_write_en  output  1  wb_valid & reg_write & (rd != 0)
retired_count  output  32  number of valid instructions retired

Behaviour:
- Reset: n_rst low asynchronously clears all registers x0..x31 and retired_count to 0. Outputs derived from them read 0 immediately. Registers stay cleared while n_rst is low, and writes are ignored. The first write takes effect at the first rising edge after n_rst deasserts.
- Load formatting (used when mem_to_reg=1). Byte lane = data_memory_out_in[8*addr_low +: 8]. Half lane = addr_low[1] ? [31:16] : [15:0]; addr_low[0] is ignored for halves, with no trap.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011, 110, 111: full word.
- wb_data = mem_to_reg ? formatted load : alu_result_in. It is valid regardless of wb_valid.
- Write: at rising clk, if wb_write_en then reg[rd] <= wb_data. Writes to x0 are discarded, and x0 always reads 0.
- Read ports are combinational with write-through bypass. If wb_write_en is high and rsN_addr == rd != 0, rsN_data = wb_data in the same cycle; otherwise it is reg[rsN_addr]. rsN_addr == 0 always yields 0, even if rd == 0 with wb_valid.
- Both ports may read the same index and may both hit the bypass simultaneously.
- retired_count increments by 1 on each rising edge with wb_valid=1, independent of reg_write (stores and branches count). It wraps from 0xFFFFFFFF to 0.
- Bubble (wb_valid=0): no register write, no count, and bypass is disabled.
- Latency: write visible via bypass in cycle 0 and from storage from cycle 1 onward.
- Reset asserted mid-write: the reset wins and the register is 0.

Test Plan:
1. Reset then read all 32 indices on both ports -> all 0, retired_count=0.
2. wb_valid=1, reg_write=1, mem_to_reg=0, rd=5, alu_result=0xDEADBEEF, rs1_addr=5 -> rs1_data=0xDEADBEEF in the same cycle (bypass). Next cycle with wb_valid=0 -> still 0xDEADBEEF, retired_count=1.
3. Write rd=0 with alu_result=0x12345678 -> wb_write_en=0, read x0 = 0, retired_count increments.
4. mem_to_reg=1, memory word=0x80FF7F01:
   - LB addr_low=3 -> 0xFFFFFF80.
   - LBU addr_low=3 -> 0x00000080.
   - LH addr_low=2 -> 0xFFFF80FF.
   - LHU addr_low=0 -> 0x00007F01.
   - LH addr_low=1 -> 0x00007F01.
   - LW -> 0x80FF7F01.
   Each is written to x7 and read back next cycle.
5. Force retired_count near wrap (0xFFFFFFFE), apply 3 valid cycles -> 0xFFFFFFFF, 0, 1. A bubble cycle leaves the count unchanged.
6. Write x9=0xA5A5A5A5, then assert n_rst low between clock edges -> x9 reads 0 immediately. A write presented during reset is ignored.
